// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO. Queued words are serialised
// back-to-back with configurable data width, parity and stop bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          wr,
  input  logic                          clr_ovf,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          TE,
  output logic                          overflow,
  output logic                          TxD
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_r;
  logic [PTR_W-1:0]     rptr_r;
  logic [LVL_W-1:0]     count_r;
  logic                 full_r;
  logic                 empty_r;
  logic                 ovf_r;

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [BIT_W-1:0]     bit_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r;
  logic                 txd_r;
  logic                 te_r;

  logic                 push_s;
  logic                 pop_s;
  logic                 cnt_last_s;
  logic                 stop_last_s;
  logic [LVL_W-1:0]     count_next_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 line_s;

  // FIFO push/pop decisions and post-edge occupancy
  always_comb begin
    push_s      = wr & ~full_r;
    cnt_last_s  = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));
    stop_last_s = (bit_r == BIT_W'(STOP_BITS - 1));
    pop_s       = 1'b0;
    if (!empty_r) begin
      if (state_r == IDLE) begin
        pop_s = 1'b1;
      end else if ((state_r == STOP) && cnt_last_s && stop_last_s) begin
        pop_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
    count_next_s = count_r + LVL_W'(push_s) - LVL_W'(pop_s);
    head_s       = mem_r[rptr_r];
  end

  // FIFO storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= din;
    end
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == LVL_W'(FIFO_DEPTH));
      empty_r <= (count_next_s == '0);
      // a dropped write beats a simultaneous clear
      if (wr && full_r) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Line level for the current serialiser state
  always_comb begin
    line_s = 1'b1;
    case (state_r)
      IDLE:    line_s = 1'b1;
      START:   line_s = 1'b0;
      DATA:    line_s = shift_r[0];
      PARITY:  line_s = par_r;
      STOP:    line_s = 1'b1;
      default: line_s = 1'b1;
    endcase
  end

  // Serialiser FSM with registered TxD and TE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bit_r   <= '0;
      shift_r <= '0;
      par_r   <= 1'b0;
      txd_r   <= 1'b1;
      te_r    <= 1'b1;
    end else begin
      txd_r <= line_s;
      te_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          bit_r <= '0;
          if (pop_s) begin
            shift_r <= head_s;
            par_r   <= parity_of(head_s);
            state_r <= START;
          end else begin
            te_r <= (count_next_s == '0);
          end
        end
        START: begin
          if (cnt_last_s) begin
            cnt_r   <= '0;
            state_r <= DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_last_s) begin
            cnt_r   <= '0;
            shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
            if (bit_r == BIT_W'(DATA_BITS - 1)) begin
              bit_r <= '0;
              if (PARITY_EN != 0) begin
                state_r <= PARITY;
              end else begin
                state_r <= STOP;
              end
            end else begin
              bit_r <= bit_r + BIT_W'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt_last_s) begin
            cnt_r   <= '0;
            state_r <= STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_last_s) begin
            cnt_r <= '0;
            if (stop_last_s) begin
              bit_r <= '0;
              // chain straight into the next frame when data is waiting
              if (pop_s) begin
                shift_r <= head_s;
                par_r   <= parity_of(head_s);
                state_r <= START;
              end else begin
                state_r <= IDLE;
                te_r    <= (count_next_s == '0);
              end
            end else begin
              bit_r <= bit_r + BIT_W'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          bit_r   <= '0;
        end
      endcase
    end
  end

  assign full     = full_r;
  assign empty    = empty_r;
  assign level    = count_r;
  assign overflow = ovf_r;
  assign TE       = te_r;
  assign TxD      = txd_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: two configurations share stimulus and are
// checked every cycle against a frame-timing reference model.
module tb_uart_tx_fifo;

  localparam int CPB0 = 4, DB0 = 8, DEP0 = 16, PE0 = 0, PO0 = 0, SB0 = 1;
  localparam int CPB1 = 3, DB1 = 7, DEP1 = 4,  PE1 = 1, PO1 = 1, SB1 = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] din = 9'd0;
  logic       wr = 1'b0;
  logic       clr_ovf = 1'b0;

  logic       full0, empty0, te0, ovf0, txd0;
  logic [4:0] level0;
  logic       full1, empty1, te1, ovf1, txd1;
  logic [2:0] level1;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB0), .DATA_BITS(DB0), .FIFO_DEPTH(DEP0),
                 .PARITY_EN(PE0), .PARITY_ODD(PO0), .STOP_BITS(SB0)) u0 (
    .clk(clk), .resetn(resetn), .din(din[7:0]), .wr(wr), .clr_ovf(clr_ovf),
    .full(full0), .empty(empty0), .level(level0), .TE(te0),
    .overflow(ovf0), .TxD(txd0));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB1), .DATA_BITS(DB1), .FIFO_DEPTH(DEP1),
                 .PARITY_EN(PE1), .PARITY_ODD(PO1), .STOP_BITS(SB1)) u1 (
    .clk(clk), .resetn(resetn), .din(din[6:0]), .wr(wr), .clr_ovf(clr_ovf),
    .full(full1), .empty(empty1), .level(level1), .TE(te1),
    .overflow(ovf1), .TxD(txd1));

  always #5 clk = ~clk;

  int cpb [2] = '{CPB0, CPB1};
  int db  [2] = '{DB0, DB1};
  int dep [2] = '{DEP0, DEP1};
  int pe  [2] = '{PE0, PE1};
  int po  [2] = '{PO0, PO1};
  int sb  [2] = '{SB0, SB1};

  int          k;
  int          n_checks;
  int          n_pass;
  int          m_cnt [2];
  int          m_pop [2];
  logic        m_ovf [2];
  logic        m_txd [2];
  logic [15:0] m_bits [2];
  logic [8:0]  m_q0 [$];
  logic [8:0]  m_q1 [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return (1 + db[i] + pe[i] + sb[i]) * cpb[i];
  endfunction

  // Frame as line levels in transmit order: start, data LSB first, parity, stops
  function automatic logic [15:0] frame_bits(input int i, input logic [8:0] w);
    logic [15:0] b;
    logic        par;
    b = '1;
    b[0] = 1'b0;
    par = 1'b0;
    for (int j = 0; j < db[i]; j++) begin
      b[1 + j] = w[j];
      par = par ^ w[j];
    end
    if (pe[i] != 0) b[1 + db[i]] = par ^ (po[i] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_pop[i] = -100000;
      m_ovf[i] = 1'b0;
      m_txd[i] = 1'b1;
      m_bits[i] = '1;
    end
    m_q0.delete();
    m_q1.delete();
  endtask

  // One rising edge: a frame popped at edge e drives the line after edges e+1..e+len
  task automatic model_step(input int i, input logic w, input logic [8:0] d, input logic c);
    int         cnt_pre, fl, mask;
    logic [8:0] word;
    logic       push, pop;
    fl = frame_len(i);
    cnt_pre = m_cnt[i];
    if (k >= m_pop[i] + 1 && k <= m_pop[i] + fl)
      m_txd[i] = m_bits[i][(k - m_pop[i] - 1) / cpb[i]];
    else
      m_txd[i] = 1'b1;
    push = w && (cnt_pre < dep[i]);
    pop  = (cnt_pre > 0) && (k >= m_pop[i] + fl);
    if (w && cnt_pre == dep[i]) m_ovf[i] = 1'b1;
    else if (c) m_ovf[i] = 1'b0;
    if (pop) begin
      word = (i == 0) ? m_q0.pop_front() : m_q1.pop_front();
      m_bits[i] = frame_bits(i, word);
      m_pop[i] = k;
      m_cnt[i]--;
    end
    if (push) begin
      mask = (1 << db[i]) - 1;
      word = d & mask[8:0];
      if (i == 0) m_q0.push_back(word);
      else m_q1.push_back(word);
      m_cnt[i]++;
    end
  endtask

  function automatic logic model_te(input int i);
    logic busy;
    busy = (k >= m_pop[i]) && (k <= m_pop[i] + frame_len(i) - 1);
    return (m_cnt[i] == 0) && !busy;
  endfunction

  task automatic check_all();
    check_eq($sformatf("u0.TxD c%0d", k), txd0, m_txd[0]);
    check_eq($sformatf("u0.TE c%0d", k), te0, model_te(0));
    check_eq($sformatf("u0.level c%0d", k), level0, m_cnt[0]);
    check_eq($sformatf("u0.full c%0d", k), full0, m_cnt[0] == dep[0]);
    check_eq($sformatf("u0.empty c%0d", k), empty0, m_cnt[0] == 0);
    check_eq($sformatf("u0.overflow c%0d", k), ovf0, m_ovf[0]);
    check_eq($sformatf("u1.TxD c%0d", k), txd1, m_txd[1]);
    check_eq($sformatf("u1.TE c%0d", k), te1, model_te(1));
    check_eq($sformatf("u1.level c%0d", k), level1, m_cnt[1]);
    check_eq($sformatf("u1.full c%0d", k), full1, m_cnt[1] == dep[1]);
    check_eq($sformatf("u1.empty c%0d", k), empty1, m_cnt[1] == 0);
    check_eq($sformatf("u1.overflow c%0d", k), ovf1, m_ovf[1]);
  endtask

  task automatic cycle(input logic w, input logic [8:0] d, input logic c);
    @(negedge clk);
    wr = w;
    din = d;
    clr_ovf = c;
    @(posedge clk);
    k++;
    model_step(0, w, d, c);
    model_step(1, w, d, c);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0, 9'd0, 1'b0);
  endtask

  // Reset asserted between edges must take effect without a clock edge
  task automatic async_reset();
    @(negedge clk);
    wr = 1'b0;
    clr_ovf = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_eq("async TxD0", txd0, 32'd1);
    check_eq("async TE0", te0, 32'd1);
    check_eq("async level0", level0, 32'd0);
    check_eq("async TxD1", txd1, 32'd1);
    check_eq("async level1", level1, 32'd0);
    check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic w, c;
    k = 0;
    n_checks = 0;
    n_pass = 0;
    model_reset();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    resetn = 1'b1;

    // single frame
    cycle(1'b1, 9'h055, 1'b0);
    idle(50);
    // back-to-back frames
    cycle(1'b1, 9'h001, 1'b0);
    cycle(1'b1, 9'h080, 1'b0);
    cycle(1'b1, 9'h0FF, 1'b0);
    idle(130);
    // fill past full, clear, then write-while-full together with clear
    for (int j = 0; j < 18; j++) cycle(1'b1, 9'($urandom_range(0, 511)), 1'b0);
    cycle(1'b0, 9'd0, 1'b1);
    cycle(1'b1, 9'h0A5, 1'b0);
    cycle(1'b1, 9'h05A, 1'b1);
    cycle(1'b0, 9'd0, 1'b1);
    idle(800);
    // parity word, then 0x7F followed by 0x00
    cycle(1'b1, 9'h007, 1'b0);
    idle(60);
    cycle(1'b1, 9'h07F, 1'b0);
    cycle(1'b1, 9'h000, 1'b0);
    idle(100);
    // reset in the middle of a frame with entries queued
    for (int j = 0; j < 6; j++) cycle(1'b1, 9'($urandom_range(0, 511)), 1'b0);
    idle(16);
    async_reset();
    idle(60);

    // randomised traffic with bursty and sparse phases
    for (int n = 0; n < 3000; n++) begin
      w = ($urandom_range(0, 99) < (((n % 1000) < 200) ? 60 : 4));
      c = ($urandom_range(0, 63) == 0);
      cycle(w, 9'($urandom_range(0, 511)), c);
      if (n == 1500) async_reset();
    end

    // drain, bounded
    for (int n = 0; n < 4000; n++) begin
      if (model_te(0) && model_te(1)) break;
      cycle(1'b0, 9'd0, 1'b0);
    end
    cycle(1'b0, 9'd0, 1'b0);
    check_eq("final TE0", te0, 32'd1);
    check_eq("final TE1", te1, 32'd1);
    check_eq("final TxD0", txd0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
